// File: rtl/haar_mac.sv
// haar_mac: one Haar lifting step per incoming pixel pair {a,b}.
// The block has a fixed two-stage pipeline and uses valid-only handshaking.
// Stage 1 registers sum and diff. Stage 2 forms L (the floor average) and
// H (the halved detail plus an offset).
// The mode and pointer sidebands travel through the pipeline with their own beat.
// A side checker flags any pointer sequence that does not match a
// raster walk of rows or columns.
module haar_mac #(
    parameter int HEIGHT   = 256,
    parameter int WIDTH    = 256,
    parameter int H_OFFSET = 128,
    localparam int PW      = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   i_mac,
    input  logic          i_mac_valid,
    input  logic          i_mac_mode,
    input  logic [PW-1:0] i_mac_row_column_pointer,
    input  logic [PW-1:0] i_mac_pixel_pointer,
    input  logic          i_bypass,
    input  logic          i_clr,
    output logic [15:0]   o_mac,
    output logic          o_mac_valid,
    output logic          o_mac_mode,
    output logic [PW-1:0] o_mac_row_column_pointer,
    output logic [PW-1:0] o_mac_pixel_pointer,
    output logic [31:0]   o_pair_count,
    output logic          o_seq_err
);

    // Row indices share the pointer width, so the image height must fit in it.
    generate
        if ($clog2(HEIGHT) > PW) begin : g_height_check
            $error("haar_mac: HEIGHT does not fit in the pointer width");
        end
    endgenerate

    // Stage-1 state
    logic                r_s1_valid;
    logic [8:0]          r_s1_sum;
    logic signed [8:0]   r_s1_diff;
    logic [7:0]          r_s1_a;
    logic [7:0]          r_s1_b;
    logic                r_s1_bypass;
    logic                r_s1_mode;
    logic [PW-1:0]       r_s1_rc;
    logic [PW-1:0]       r_s1_pp;

    // Stage-2 (output) state
    logic [15:0]         r_mac;
    logic                r_mac_valid;
    logic                r_mode;
    logic [PW-1:0]       r_rc;
    logic [PW-1:0]       r_pp;

    // Sequence tracker and status
    logic                r_prev_valid;
    logic                r_prev_mode;
    logic [PW-1:0]       r_prev_rc;
    logic [PW-1:0]       r_prev_pp;
    logic                r_seq_err;
    logic [31:0]         r_pair_count;

    // Combinational datapath
    logic [7:0]          w_a;
    logic [7:0]          w_b;
    logic [8:0]          w_sum;
    logic signed [8:0]   w_diff;
    logic [7:0]          w_l;
    logic [7:0]          w_h;
    logic [15:0]         w_result;
    logic [PW-1:0]       w_pp_next;
    logic [PW-1:0]       w_rc_next;
    logic                w_seq_viol;

    assign w_a    = i_mac[15:8];
    assign w_b    = i_mac[7:0];
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = $signed({1'b0, w_a}) - $signed({1'b0, w_b});

    // L is the floor average. H is the arithmetic half of the difference plus the offset.
    // H wraps modulo 256 and is not saturated.
    assign w_l      = 8'(r_s1_sum >> 1);
    assign w_h      = 8'(r_s1_diff >>> 1) + 8'(H_OFFSET);
    assign w_result = r_s1_bypass ? {r_s1_a, r_s1_b} : {w_l, w_h};

    // Judge the current valid input against the previously accepted input.
    always_comb begin
        w_pp_next  = r_prev_pp + PW'(2);
        w_rc_next  = r_prev_rc + PW'(1);
        w_seq_viol = 1'b0;
        if (i_mac_valid && r_prev_valid) begin
            if (i_mac_pixel_pointer[0]) begin
                w_seq_viol = 1'b1;
            end else if (i_mac_pixel_pointer != '0) begin
                if ((i_mac_mode != r_prev_mode) ||
                    (i_mac_pixel_pointer != w_pp_next) ||
                    (i_mac_row_column_pointer != r_prev_rc)) begin
                    w_seq_viol = 1'b1;
                end
            end else if ((i_mac_mode == r_prev_mode) &&
                         (i_mac_row_column_pointer != w_rc_next) &&
                         (i_mac_row_column_pointer != '0)) begin
                w_seq_viol = 1'b1;
            end
        end
    end

    // Stage 1: capture sum/diff, the raw pair and the sidebands. Data holds when the input is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sum    <= '0;
            r_s1_diff   <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_bypass <= 1'b0;
            r_s1_mode   <= 1'b0;
            r_s1_rc     <= '0;
            r_s1_pp     <= '0;
        end else begin
            r_s1_valid <= i_mac_valid;
            if (i_mac_valid) begin
                r_s1_sum    <= w_sum;
                r_s1_diff   <= w_diff;
                r_s1_a      <= w_a;
                r_s1_b      <= w_b;
                r_s1_bypass <= i_bypass;
                r_s1_mode   <= i_mac_mode;
                r_s1_rc     <= i_mac_row_column_pointer;
                r_s1_pp     <= i_mac_pixel_pointer;
            end
        end
    end

    // Stage 2: register the result and the sidebands of the same beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mac       <= '0;
            r_mac_valid <= 1'b0;
            r_mode      <= 1'b0;
            r_rc        <= '0;
            r_pp        <= '0;
        end else begin
            r_mac_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_mac  <= w_result;
                r_mode <= r_s1_mode;
                r_rc   <= r_s1_rc;
                r_pp   <= r_s1_pp;
            end
        end
    end

    // Remember the last accepted pointers. A clear forgets them, so the next input starts fresh.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_valid <= 1'b0;
            r_prev_mode  <= 1'b0;
            r_prev_rc    <= '0;
            r_prev_pp    <= '0;
        end else if (i_clr) begin
            r_prev_valid <= 1'b0;
        end else if (i_mac_valid) begin
            r_prev_valid <= 1'b1;
            r_prev_mode  <= i_mac_mode;
            r_prev_rc    <= i_mac_row_column_pointer;
            r_prev_pp    <= i_mac_pixel_pointer;
        end
    end

    // Sticky sequence error. Only i_clr or reset releases it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seq_err <= 1'b0;
        end else if (i_clr) begin
            r_seq_err <= 1'b0;
        end else if (w_seq_viol) begin
            r_seq_err <= 1'b1;
        end
    end

    // Count emitted results, saturating at all-ones. Clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pair_count <= '0;
        end else if (i_clr) begin
            r_pair_count <= '0;
        end else if (r_mac_valid && (r_pair_count != '1)) begin
            r_pair_count <= r_pair_count + 32'd1;
        end
    end

    assign o_mac                    = r_mac;
    assign o_mac_valid              = r_mac_valid;
    assign o_mac_mode               = r_mode;
    assign o_mac_row_column_pointer = r_rc;
    assign o_mac_pixel_pointer      = r_pp;
    assign o_pair_count             = r_pair_count;
    assign o_seq_err                = r_seq_err;

endmodule

// File: tb/tb_haar_mac.sv
// Testbench for haar_mac. The stimulus side pushes the expected results into a queue.
// A negedge monitor pops an entry and compares it, including the cycle it should appear in.
`timescale 1ns/1ps
module tb_haar_mac;

    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   i_mac = '0;
    logic          i_mac_valid = 1'b0;
    logic          i_mac_mode = 1'b0;
    logic [PW-1:0] i_mac_row_column_pointer = '0;
    logic [PW-1:0] i_mac_pixel_pointer = '0;
    logic          i_bypass = 1'b0;
    logic          i_clr = 1'b0;
    logic [15:0]   o_mac;
    logic          o_mac_valid;
    logic          o_mac_mode;
    logic [PW-1:0] o_mac_row_column_pointer;
    logic [PW-1:0] o_mac_pixel_pointer;
    logic [31:0]   o_pair_count;
    logic          o_seq_err;

    haar_mac #(.HEIGHT(256), .WIDTH(256), .H_OFFSET(128)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .i_mac                    (i_mac),
        .i_mac_valid              (i_mac_valid),
        .i_mac_mode               (i_mac_mode),
        .i_mac_row_column_pointer (i_mac_row_column_pointer),
        .i_mac_pixel_pointer      (i_mac_pixel_pointer),
        .i_bypass                 (i_bypass),
        .i_clr                    (i_clr),
        .o_mac                    (o_mac),
        .o_mac_valid              (o_mac_valid),
        .o_mac_mode               (o_mac_mode),
        .o_mac_row_column_pointer (o_mac_row_column_pointer),
        .o_mac_pixel_pointer      (o_mac_pixel_pointer),
        .o_pair_count             (o_pair_count),
        .o_seq_err                (o_seq_err)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0]   mac;
        logic          mode;
        logic [PW-1:0] rc;
        logic [PW-1:0] pp;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    bit   track = 1'b1;

    // Sequence-rule model state
    bit            m_prev_valid = 1'b0;
    logic          m_prev_mode = 1'b0;
    logic [PW-1:0] m_prev_rc = '0;
    logic [PW-1:0] m_prev_pp = '0;
    bit            m_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference Haar step in plain integer arithmetic.
    // The +512 shift makes the integer division act as a floor for negative differences.
    function automatic logic [15:0] ref_haar(input int a, input int b);
        int l;
        int h;
        l = (a + b) / 2;
        h = ((a - b + 512) / 2 - 256 + 128) % 256;
        return {l[7:0], h[7:0]};
    endfunction

    // Pointer-walk legality, as a fresh check against the previous accepted beat.
    function automatic bit seq_bad(input logic m, input logic [PW-1:0] rc, input logic [PW-1:0] pp);
        int nxt_pp;
        int nxt_rc;
        if (!m_prev_valid) return 1'b0;
        if (pp % 2 == 1) return 1'b1;
        nxt_pp = (int'(m_prev_pp) + 2) % 256;
        nxt_rc = (int'(m_prev_rc) + 1) % 256;
        if (pp != 0) return (m != m_prev_mode) || (int'(pp) != nxt_pp) || (rc != m_prev_rc);
        if (m == m_prev_mode) return !((int'(rc) == nxt_rc) || (rc == 0));
        return 1'b0;
    endfunction

    // Present one beat for the next rising edge. The caller must already be at a negedge.
    task automatic put_beat(input logic [7:0] a, input logic [7:0] b, input logic m,
                            input logic [PW-1:0] rc, input logic [PW-1:0] pp, input logic byp);
        exp_t e;
        i_mac = {a, b};
        i_mac_valid = 1'b1;
        i_mac_mode = m;
        i_mac_row_column_pointer = rc;
        i_mac_pixel_pointer = pp;
        i_bypass = byp;
        e.mac  = byp ? {a, b} : ref_haar(int'(a), int'(b));
        e.mode = m;
        e.rc   = rc;
        e.pp   = pp;
        e.cyc  = cyc + 2;
        if (track) sb.push_back(e);
        if (seq_bad(m, rc, pp)) m_err = 1'b1;
        m_prev_valid = 1'b1;
        m_prev_mode  = m;
        m_prev_rc    = rc;
        m_prev_pp    = pp;
    endtask

    task automatic idle(input int n);
        i_mac_valid = 1'b0;
        i_bypass = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        i_mac_valid = 1'b0;
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        m_prev_valid = 1'b0;
        m_err = 1'b0;
        chk("clr_count", 64'(o_pair_count), 64'd0);
        chk("clr_err", 64'(o_seq_err), 64'd0);
    endtask

    // Monitor: every presented result must match the next scoreboard entry in data and timing.
    always @(negedge clk) begin
        if (o_mac_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%h required=none (t=%0t)", o_mac, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_cycle", 64'(cyc), 64'(e.cyc));
                chk("out_mac", 64'(o_mac), 64'(e.mac));
                chk("out_mode", 64'(o_mac_mode), 64'(e.mode));
                chk("out_rc", 64'(o_mac_row_column_pointer), 64'(e.rc));
                chk("out_pp", 64'(o_mac_pixel_pointer), 64'(e.pp));
                $display("OUT cyc=%0d mac=%h mode=%0d rc=%0d pp=%0d", cyc, o_mac, o_mac_mode,
                         o_mac_row_column_pointer, o_mac_pixel_pointer);
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_out actual=none required=%h at cycle %0d", e.mac, e.cyc);
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PW-1:0] rc;
        logic [PW-1:0] pp;
        logic          m;
        int            kind;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(o_mac_valid), 64'd0);
        chk("rst_mac", 64'(o_mac), 64'd0);
        chk("rst_count", 64'(o_pair_count), 64'd0);
        chk("rst_err", 64'(o_seq_err), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed examples
        put_beat(8'd200, 8'd100, 1'b0, 8'd3, 8'd4, 1'b0);
        @(negedge clk);
        put_beat(8'd0, 8'd255, 1'b0, 8'd3, 8'd6, 1'b0);
        @(negedge clk);
        put_beat(8'd255, 8'd0, 1'b0, 8'd3, 8'd8, 1'b0);
        @(negedge clk);
        idle(5);
        chk("dir_count", 64'(o_pair_count), 64'd3);
        chk("dir_err", 64'(o_seq_err), 64'd0);
        chk("dir_sb_empty", 64'(sb.size()), 64'd0);

        // Two full rows, back to back
        clr_pulse();
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 128; p++) begin
                put_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0,
                         PW'(r), PW'(2 * p), 1'b0);
                @(negedge clk);
            end
        end
        idle(5);
        chk("row_count", 64'(o_pair_count), 64'd256);
        chk("row_err", 64'(o_seq_err), 64'd0);
        chk("row_sb_empty", 64'(sb.size()), 64'd0);

        // pp sequence 0,2,6: the error appears one cycle after the bad beat
        clr_pulse();
        put_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 8'd5, 8'd0, 1'b0);
        @(negedge clk);
        chk("skip_err_a", 64'(o_seq_err), 64'd0);
        put_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 8'd5, 8'd2, 1'b0);
        @(negedge clk);
        chk("skip_err_b", 64'(o_seq_err), 64'd0);
        put_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 8'd5, 8'd6, 1'b0);
        @(negedge clk);
        i_mac_valid = 1'b0;
        chk("skip_err_set", 64'(o_seq_err), 64'd1);
        idle(5);
        chk("skip_err_sticky", 64'(o_seq_err), 64'd1);
        clr_pulse();

        // Bypass beats mixed with normal beats
        put_beat(8'hAB, 8'hCD, 1'b1, 8'd9, 8'd0, 1'b1);
        for (int p = 1; p < 10; p++) begin
            @(negedge clk);
            put_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 8'd9,
                     PW'(2 * p), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        idle(5);
        chk("byp_count", 64'(o_pair_count), 64'd10);
        chk("byp_err", 64'(o_seq_err), 64'd0);

        // Randomised pointer walks, with the sticky error checked against the rule model
        for (int round = 0; round < 4; round++) begin
            clr_pulse();
            for (int k = 0; k < 40; k++) begin
                if (k != 0) begin
                    @(negedge clk);
                    chk("rand_seq_err", 64'(o_seq_err), 64'(m_err));
                end
                if ($urandom_range(0, 3) == 0) begin
                    i_mac_valid = 1'b0;
                end else begin
                    kind = $urandom_range(0, 15);
                    m  = m_prev_mode;
                    rc = m_prev_rc;
                    pp = m_prev_pp + PW'(2);
                    if (!m_prev_valid) begin
                        m  = 1'($urandom_range(0, 1));
                        rc = PW'($urandom_range(0, 255));
                        pp = PW'(2 * $urandom_range(0, 120));
                    end else if (kind < 10) begin
                        // continue along the current line
                    end else if (kind < 12) begin
                        rc = m_prev_rc + PW'(1);
                        pp = '0;
                    end else if (kind < 13) begin
                        m  = ~m_prev_mode;
                        rc = PW'($urandom_range(0, 255));
                        pp = '0;
                    end else if (kind < 14) begin
                        rc = '0;
                        pp = '0;
                    end else begin
                        m  = 1'($urandom_range(0, 1));
                        rc = PW'($urandom_range(0, 255));
                        pp = PW'($urandom_range(0, 255));
                    end
                    put_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), m, rc, pp,
                             1'b0);
                end
            end
            @(negedge clk);
            chk("rand_seq_err_last", 64'(o_seq_err), 64'(m_err));
            idle(5);
            chk("rand_sb_empty", 64'(sb.size()), 64'd0);
        end

        // Reset with two beats in flight: they are discarded and nothing emerges later
        clr_pulse();
        track = 1'b0;
        put_beat(8'd10, 8'd20, 1'b0, 8'd1, 8'd0, 1'b0);
        @(negedge clk);
        put_beat(8'd30, 8'd40, 1'b0, 8'd1, 8'd2, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_mac_valid = 1'b0;
        #1;
        chk("midrst_valid", 64'(o_mac_valid), 64'd0);
        chk("midrst_count", 64'(o_pair_count), 64'd0);
        chk("midrst_err", 64'(o_seq_err), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        track = 1'b1;
        m_prev_valid = 1'b0;
        m_err = 1'b0;
        idle(6);
        chk("midrst_no_late", 64'(o_pair_count), 64'd0);

        // The pipeline works again after reset
        @(negedge clk);
        put_beat(8'd7, 8'd8, 1'b1, 8'd2, 8'd0, 1'b0);
        @(negedge clk);
        idle(5);
        chk("post_rst_count", 64'(o_pair_count), 64'd1);
        chk("post_rst_sb_empty", 64'(sb.size()), 64'd0);
        chk("post_rst_err", 64'(o_seq_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
